nn_layer_sequencer: RTL

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

---
 rtl/nn_pkg.sv | 36 +++
 rtl/nn_index_counter.sv | 33 +++
 rtl/nn_layer_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the NN layer sequencer and its network controller:
// layer encoding, sequencer state type, default layer sizes and weight-memory map.
package nn_pkg;

    typedef enum logic [1:0] {
        LAYER_NONE = 2'd0,
        LAYER_H1   = 2'd1,
        LAYER_H2   = 2'd2,
        LAYER_OUT  = 2'd3
    } layer_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BIAS,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_N_IN  = 16;
    localparam int unsigned DEF_N_H1  = 8;
    localparam int unsigned DEF_N_H2  = 8;
    localparam int unsigned DEF_N_OUT = 10;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NEU_W  = 4;

    // Weight memory layout: H1 weights, H2 weights, OUT weights, then bias words.
    localparam int unsigned BASE_H1   = 0;
    localparam int unsigned BASE_H2   = DEF_N_IN * DEF_N_H1;
    localparam int unsigned BASE_OUT  = BASE_H2 + DEF_N_H1 * DEF_N_H2;
    localparam int unsigned BIAS_BASE = BASE_OUT + DEF_N_H2 * DEF_N_OUT;

endpackage

// File: rtl/nn_index_counter.sv
// Index counter with a run-time terminal value: synchronous clear, enable,
// wrap to zero after the terminal value, and a wrap flag while at the terminal value.
module nn_index_counter
    import nn_pkg::*;
#(
    parameter int unsigned MOD = 16,
    localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = (r_count == i_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Per-layer MAC sequencer: walks neurons and inputs, drives accumulator/weight-memory
// controls. Define NN_SEQ_BIAS_EN to add a per-neuron bias fetch cycle (bias_en).
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_H1  = DEF_N_H1,
    parameter int unsigned N_H2  = DEF_N_H2,
    parameter int unsigned N_OUT = DEF_N_OUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hidden,
    input  logic              ld1,
    input  logic              ld2,
    input  logic              batch_done,
    input  logic              done,
    output logic              calculation_done,
    output logic [1:0]        layer,
    output logic [IDX_W-1:0]  in_idx,
    output logic [NEU_W-1:0]  neu_idx,
    output logic [ADDR_W-1:0] w_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              wr_en,
`ifdef NN_SEQ_BIAS_EN
    output logic              bias_en,
`endif
    output logic              relu_en
);

    localparam logic [ADDR_W-1:0] A_BASE_H2  = ADDR_W'(N_IN * N_H1);
    localparam logic [ADDR_W-1:0] A_BASE_OUT = ADDR_W'(N_IN * N_H1 + N_H1 * N_H2);

    state_t              r_state;
    layer_t              r_layer;
    logic [IDX_W-1:0]    r_fan_last;
    logic [NEU_W-1:0]    r_neu_last;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_w_addr;
    logic                r_acc_clr, r_acc_en, r_wr_en, r_relu_en, r_calc_done;

    layer_t              w_phase;
    logic [ADDR_W-1:0]   w_geo_base;
    logic [IDX_W-1:0]    w_geo_fan_last;
    logic [NEU_W-1:0]    w_geo_neu_last;
    logic                w_in_wrap, w_neu_wrap;

`ifdef NN_SEQ_BIAS_EN
    localparam logic [ADDR_W-1:0] A_BIAS = ADDR_W'(N_IN * N_H1 + N_H1 * N_H2 + N_H2 * N_OUT);
    logic [ADDR_W-1:0] r_bias_off;
    logic [ADDR_W-1:0] w_geo_bias_off;
    logic              r_bias_en;
    assign bias_en = r_bias_en;
`endif

    always_comb begin
        w_phase = LAYER_NONE;
        if (hidden && ld1)                      w_phase = LAYER_H1;
        else if (hidden && ld2)                 w_phase = LAYER_H2;
        else if (!hidden && !batch_done && !done) w_phase = LAYER_OUT;
    end

    always_comb begin
        w_geo_base     = A_BASE_OUT;
        w_geo_fan_last = IDX_W'(N_H2 - 1);
        w_geo_neu_last = NEU_W'(N_OUT - 1);
`ifdef NN_SEQ_BIAS_EN
        w_geo_bias_off = ADDR_W'(N_H1 + N_H2);
`endif
        case (w_phase)
            LAYER_H1: begin
                w_geo_base     = '0;
                w_geo_fan_last = IDX_W'(N_IN - 1);
                w_geo_neu_last = NEU_W'(N_H1 - 1);
`ifdef NN_SEQ_BIAS_EN
                w_geo_bias_off = '0;
`endif
            end
            LAYER_H2: begin
                w_geo_base     = A_BASE_H2;
                w_geo_fan_last = IDX_W'(N_H1 - 1);
                w_geo_neu_last = NEU_W'(N_H2 - 1);
`ifdef NN_SEQ_BIAS_EN
                w_geo_bias_off = ADDR_W'(N_H1);
`endif
            end
            default: ;
        endcase
    end

    // in_idx holds at fan_in-1 through WRITE and is cleared outside MAC, so
    // w_addr tracks base + neu_idx*fan_in + in_idx as a simple running pointer.
    nn_index_counter #(.MOD(1 << IDX_W)) u_in_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (r_state != ST_MAC),
        .i_en    ((r_state == ST_MAC) && !w_in_wrap),
        .i_last  (r_fan_last),
        .o_count (in_idx),
        .o_wrap  (w_in_wrap)
    );

    nn_index_counter #(.MOD(1 << NEU_W)) u_neu_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (r_state == ST_IDLE),
        .i_en    (r_state == ST_WRITE),
        .i_last  (r_neu_last),
        .o_count (neu_idx),
        .o_wrap  (w_neu_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_layer     <= LAYER_NONE;
            r_fan_last  <= '0;
            r_neu_last  <= '0;
            r_ptr       <= '0;
            r_w_addr    <= '0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_relu_en   <= 1'b0;
            r_calc_done <= 1'b0;
`ifdef NN_SEQ_BIAS_EN
            r_bias_off  <= '0;
            r_bias_en   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_phase != LAYER_NONE) begin
                        r_state    <= ST_CLEAR;
                        r_layer    <= w_phase;
                        r_fan_last <= w_geo_fan_last;
                        r_neu_last <= w_geo_neu_last;
                        r_ptr      <= w_geo_base;
                        r_w_addr   <= w_geo_base;
                        r_acc_clr  <= 1'b1;
`ifdef NN_SEQ_BIAS_EN
                        r_bias_off <= w_geo_bias_off;
`endif
                    end
                end
                ST_CLEAR: begin
                    r_acc_clr <= 1'b0;
`ifdef NN_SEQ_BIAS_EN
                    r_state   <= ST_BIAS;
                    r_bias_en <= 1'b1;
                    r_w_addr  <= A_BIAS + r_bias_off + {{(ADDR_W-NEU_W){1'b0}}, neu_idx};
`else
                    r_state   <= ST_MAC;
                    r_acc_en  <= 1'b1;
`endif
                end
`ifdef NN_SEQ_BIAS_EN
                ST_BIAS: begin
                    r_bias_en <= 1'b0;
                    r_state   <= ST_MAC;
                    r_acc_en  <= 1'b1;
                    r_w_addr  <= r_ptr;
                end
`endif
                ST_MAC: begin
                    if (w_in_wrap) begin
                        r_state   <= ST_WRITE;
                        r_acc_en  <= 1'b0;
                        r_wr_en   <= 1'b1;
                        r_relu_en <= (r_layer != LAYER_OUT);
                    end else begin
                        r_ptr    <= r_ptr + 1'b1;
                        r_w_addr <= r_ptr + 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wr_en   <= 1'b0;
                    r_relu_en <= 1'b0;
                    if (w_neu_wrap) begin
                        r_state     <= ST_DONE;
                        r_calc_done <= 1'b1;
                        r_ptr       <= '0;
                        r_w_addr    <= '0;
                    end else begin
                        r_state   <= ST_CLEAR;
                        r_acc_clr <= 1'b1;
                        r_ptr     <= r_ptr + 1'b1;
                        r_w_addr  <= r_ptr + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_calc_done <= 1'b0;
                    r_layer     <= LAYER_NONE;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign calculation_done = r_calc_done;
    assign layer            = r_layer;
    assign w_addr           = r_w_addr;
    assign acc_clr          = r_acc_clr;
    assign acc_en           = r_acc_en;
    assign wr_en            = r_wr_en;
    assign relu_en          = r_relu_en;

endmodule
